// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Supports lock-held bursts, address range checking and read-data routing.
module dmem_arbiter #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_Wdata,
  input  logic [DATA_W-1:0] mem_Rdata
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t state, state_nxt;
  logic   rr_last;

  logic [1:0]             vld, we, lock, gnt, rvalid, err;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata, rdata;

  logic              acc, gid, g_we, g_lock, in_range;
  logic [ADDR_W-1:0] g_addr, addr_q;
  logic [DATA_W-1:0] g_wdata, wdata_q;
  logic              rsp_pend, rsp_rd, rsp_id, rsp_err;

  assign vld   = {req1_valid, req0_valid};
  assign we    = {req1_we,    req0_we};
  assign lock  = {req1_lock,  req0_lock};
  assign addr  = {req1_addr,  req0_addr};
  assign wdata = {req1_wdata, req0_wdata};

  // Grant and next-state; grant is forced off while reset is asserted.
  always_comb begin
    gnt       = '0;
    state_nxt = state;
    unique case (state)
      ARB:     gnt = (vld == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : vld;
      LOCK0:   gnt = {1'b0, vld[0]};
      LOCK1:   gnt = {vld[1], 1'b0};
      default: gnt = '0;
    endcase
    if (!rst_n) gnt = '0;
    acc     = |gnt;
    gid     = gnt[1];
    g_we    = we[gid];
    g_lock  = lock[gid];
    g_addr  = addr[gid];
    g_wdata = wdata[gid];
    // Full-width compare so high address bits cannot alias into range.
    in_range = (g_addr < DEPTH_A);
    if (acc)
      state_nxt = g_lock ? (gid ? LOCK1 : LOCK0) : ARB;
    else if (state != ARB)
      state_nxt = ARB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_last  <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_pend <= 1'b0;
      rsp_rd   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rsp_pend <= acc & (~g_we | ~in_range);
      rsp_rd   <= acc & ~g_we;
      rsp_err  <= acc & ~in_range;
      if (acc) begin
        rr_last <= gid;
        addr_q  <= g_addr;
        wdata_q <= g_wdata;
        rsp_id  <= gid;
      end
    end
  end

  assign mem_MemWrite = acc & g_we & in_range;
  assign mem_MemRead  = acc & ~g_we & in_range;
  assign mem_Addr     = acc ? g_addr  : addr_q;
  assign mem_Wdata    = acc ? g_wdata : wdata_q;

  // Response fan-out: only the requester that issued the access sees a pulse.
  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign rvalid[i] = rsp_pend & rsp_rd & (rsp_id == 1'(i));
    assign err[i]    = rsp_pend & rsp_err & (rsp_id == 1'(i));
    assign rdata[i]  = (rvalid[i] & ~rsp_err) ? mem_Rdata : '0;
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_err    = err[0];
  assign req1_err    = err[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word registered-read memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_MemWrite, mem_MemRead;
  logic [31:0] mem_Addr, mem_Wdata, mem_Rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(32), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_Addr(mem_Addr), .mem_Wdata(mem_Wdata), .mem_Rdata(mem_Rdata)
  );

  // Memory contents start as 0x1000 + address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
      mem_Rdata <= '0;
    end else begin
      if (mem_MemWrite) mem[mem_Addr[4:0]] <= mem_Wdata;
      if (mem_MemRead)  mem_Rdata <= mem[mem_Addr[4:0]];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = w; req0_lock = l; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = w; req1_lock = l; req1_addr = a; req1_wdata = d;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 1'b0, 0, 0);
    set1(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("rst_rdy0",   req0_ready,   1'b0);
    chk1 ("rst_rv0",    req0_rvalid,  1'b0);
    chk1 ("rst_err0",   req0_err,     1'b0);
    chk32("rst_rdata0", req0_rdata,   32'h0);
    chk1 ("rst_rv1",    req1_rvalid,  1'b0);
    chk1 ("rst_mrd",    mem_MemRead,  1'b0);
    chk1 ("rst_mwr",    mem_MemWrite, 1'b0);
    chk32("rst_addr",   mem_Addr,     32'h0);
    chk32("rst_wdata",  mem_Wdata,    32'h0);
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Simultaneous reads: requester 0 wins the first tie.
    set0(1'b1, 1'b0, 1'b0, 3, 0);
    set1(1'b1, 1'b0, 1'b0, 4, 0);
    @(negedge clk);
    chk1 ("t1_rdy0", req0_ready,  1'b1);
    chk1 ("t1_rdy1", req1_ready,  1'b0);
    chk1 ("t1_mrd",  mem_MemRead, 1'b1);
    chk32("t1_addr", mem_Addr,    32'd3);
    cyc();
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("t1_rv0",    req0_rvalid, 1'b1);
    chk32("t1_rdata0", req0_rdata,  32'h1003);
    chk1 ("t1_rdy1b",  req1_ready,  1'b1);
    chk32("t1_addr1",  mem_Addr,    32'd4);
    cyc();
    set1(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("t1_rv1",    req1_rvalid, 1'b1);
    chk32("t1_rdata1", req1_rdata,  32'h1004);
    chk1 ("t1_rv0b",   req0_rvalid, 1'b0);
    cyc();

    // Continuous contention alternates 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++) begin
      set0(1'b1, 1'b0, 1'b0, 0, 0);
      set1(1'b1, 1'b0, 1'b0, 1, 0);
      @(negedge clk);
      chk1("rr_rdy0", req0_ready, (k % 2) == 0);
      chk1("rr_rdy1", req1_ready, (k % 2) == 1);
      if (k > 0) begin
        chk1("rr_rv0", req0_rvalid, ((k - 1) % 2) == 0);
        chk1("rr_rv1", req1_rvalid, ((k - 1) % 2) == 1);
      end
      cyc();
    end
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    set1(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("rr_rv1_last", req1_rvalid, 1'b1);
    chk32("rr_rdata1",   req1_rdata,  32'h1001);
    cyc();

    // Solo in-range write by requester 0: no response pulse follows.
    set0(1'b1, 1'b1, 1'b0, 10, 32'h55);
    @(negedge clk);
    chk1("w_rdy0", req0_ready,   1'b1);
    chk1("w_mwr",  mem_MemWrite, 1'b1);
    cyc();

    // Requester 1 locked write burst while requester 0 keeps asking.
    for (int k = 0; k < 3; k++) begin
      set0(1'b1, 1'b0, 1'b0, 7, 0);
      set1(1'b1, 1'b1, k < 2, 7, 32'hDEADBEEF);
      @(negedge clk);
      chk1 ("lk_rdy0",  req0_ready,   1'b0);
      chk1 ("lk_rdy1",  req1_ready,   1'b1);
      chk1 ("lk_mwr",   mem_MemWrite, 1'b1);
      chk32("lk_wdata", mem_Wdata,    32'hDEADBEEF);
      if (k == 0) begin
        chk1("w_norv0",  req0_rvalid, 1'b0);
        chk1("w_noerr0", req0_err,    1'b0);
      end
      cyc();
    end
    set1(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("lk_after_rdy0", req0_ready,  1'b1);
    chk1 ("lk_after_mrd",  mem_MemRead, 1'b1);
    chk32("lk_after_addr", mem_Addr,    32'd7);
    cyc();
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("lk_rv0",    req0_rvalid, 1'b1);
    chk32("lk_rdata0", req0_rdata,  32'hDEADBEEF);
    cyc();

    // Range boundary: 31 ok, 32 and high-bit address are errors.
    set0(1'b1, 1'b0, 1'b0, 31, 0);
    @(negedge clk);
    chk1("b31_rdy0", req0_ready,  1'b1);
    chk1("b31_mrd",  mem_MemRead, 1'b1);
    cyc();
    set0(1'b1, 1'b0, 1'b0, 32, 0);
    @(negedge clk);
    chk1 ("b32_mrd",    mem_MemRead, 1'b0);
    chk1 ("b32_rdy0",   req0_ready,  1'b1);
    chk1 ("b31_rv0",    req0_rvalid, 1'b1);
    chk1 ("b31_err0",   req0_err,    1'b0);
    chk32("b31_rdata0", req0_rdata,  32'h101F);
    cyc();
    set0(1'b1, 1'b0, 1'b0, 32'h8000_0003, 0);
    @(negedge clk);
    chk1 ("b32_rv0",    req0_rvalid, 1'b1);
    chk1 ("b32_err0",   req0_err,    1'b1);
    chk32("b32_rdata0", req0_rdata,  32'h0);
    chk1 ("hi_mrd",     mem_MemRead, 1'b0);
    chk1 ("hi_rdy0",    req0_ready,  1'b1);
    cyc();
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1("hi_rv0",  req0_rvalid, 1'b1);
    chk1("hi_err0", req0_err,    1'b1);
    cyc();

    // Out-of-range write: error pulse only, no strobe.
    set0(1'b1, 1'b1, 1'b0, 40, 32'h77);
    @(negedge clk);
    chk1 ("ow_mwr",  mem_MemWrite, 1'b0);
    chk1 ("ow_rdy0", req0_ready,   1'b1);
    chk32("ow_addr", mem_Addr,     32'd40);
    chk1 ("ow_err0_pre", req0_err, 1'b0);
    cyc();
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("ow_err0",  req0_err,     1'b1);
    chk1 ("ow_rv0",   req0_rvalid,  1'b0);
    chk32("ow_hold",  mem_Addr,     32'd40);
    chk1 ("ow_mwr2",  mem_MemWrite, 1'b0);
    cyc();
    @(negedge clk);
    chk1("ow_err0_end", req0_err, 1'b0);
    cyc();

    // Reset right after a read accept drops the response.
    set0(1'b1, 1'b0, 1'b0, 2, 0);
    @(negedge clk);
    chk1("mr_mrd", mem_MemRead, 1'b1);
    cyc();
    rst_n = 1'b0;
    set0(1'b0, 1'b0, 1'b0, 0, 0);
    set1(1'b1, 1'b0, 1'b0, 4, 0);
    @(negedge clk);
    chk1 ("mr_rv0",   req0_rvalid, 1'b0);
    chk1 ("mr_rdy1",  req1_ready,  1'b0);
    chk1 ("mr_mrd0",  mem_MemRead, 1'b0);
    chk32("mr_addr0", mem_Addr,    32'h0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk1 ("mr_rdy1b", req1_ready,  1'b1);
    chk1 ("mr_mrd1",  mem_MemRead, 1'b1);
    chk32("mr_addr4", mem_Addr,    32'd4);
    cyc();
    set1(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk1 ("mr_rv1",    req1_rvalid, 1'b1);
    chk32("mr_rdata1", req1_rdata,  32'h1004);
    chk1 ("mr_rv0b",   req0_rvalid, 1'b0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (32 x 32-bit words, word-addressed, synchronous write, registered read with 1-cycle latency, separate MemRead/MemWrite strobes).
- Requester 0 is the pipeline MEM stage; requester 1 is the loader/debug port.
- Performs round-robin arbitration with an optional lock for back-to-back bursts.
- Range-checks addresses and routes registered read data back to the requester that issued the read.

Parameters:
- DEPTH, 32: number of memory words; valid word addresses are 0..DEPTH-1.
- ADDR_W, 32: width of requester and memory address buses.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an access pending.
- req0_we  in  1  1 = write, 0 = read.
- req0_lock  in  1  keep the grant after this access.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  access accepted this cycle (combinational).
- req0_rvalid  out  1  read data / error valid (one-cycle pulse).
- req0_rdata  out  DATA_W  read data.
- req0_err  out  1  out-of-range access (one-cycle pulse).
- req1_valid, req1_we, req1_lock, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata, req1_err: identical to requester 0.
- mem_MemWrite  out  1  write strobe to memory.
- mem_MemRead  out  1  read strobe to memory.
- mem_Addr  out  ADDR_W  memory address.
- mem_Wdata  out  DATA_W  memory write data.
- mem_Rdata  in  DATA_W  memory registered read data.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=ARB, rr_last=1 (requester 0 wins the first tie).
  - rsp_pend=0, rsp_id=0, rsp_err=0.
  - All rvalid/err/rdata outputs are 0; all ready outputs are 0.
  - mem_MemWrite=0, mem_MemRead=0, mem_Addr=0, mem_Wdata=0.
- States and transitions:
  - ARB: grant the single valid requester. If both are valid, grant the one not equal to rr_last.
  - LOCK0 / LOCK1: only the owner can be granted; the other requester's ready=0 even if its valid=1.
  - On an accepted access (valid & ready) with lock=1: go to/stay in LOCKn.
  - On an accepted access with lock=0: return to ARB.
  - In LOCKn, if the owner deasserts valid: return to ARB on the next edge.
- Accept rule: in the cycle a requester is granted, readyN=1 combinationally. At most one ready is high per cycle. Accept occurs when valid & ready are both high.
- rr_last updates to the granted id on every accept.
- Memory drive in accept cycle T (combinational from the granted requester):
  - mem_Addr and mem_Wdata follow the granted requester.
  - mem_MemWrite = we & in_range.
  - mem_MemRead = ~we & in_range.
  - in_range = addr < DEPTH.
  - With no accept, both strobes are 0 and mem_Addr/mem_Wdata hold their last value.
- Response, registered at the end of cycle T, visible in cycle T+1 on the granted requester only:
  - In-range read: rvalid=1, rdata=mem_Rdata.
  - Out-of-range read: rvalid=1, err=1, rdata=0.
  - Out-of-range write: err=1, rvalid=0.
  - In-range write: no response pulse.
  - Outputs of the non-responding requester stay 0. All pulses last exactly one cycle.
- Throughput: one accept per cycle. Back-to-back reads yield back-to-back rvalid pulses. A response in T+1 can coexist with a new accept in T+1.
- rdata is valid only while rvalid=1; otherwise it is 0.
- Boundaries:
  - Address DEPTH-1 is in range; address DEPTH is an error.
  - The upper address bits participate in the range compare (no truncation).
- Reset mid-operation:
  - Pending responses are dropped and no rvalid is issued.
  - Any lock is released and rr_last returns to 1.
  - Memory strobes go to 0 immediately.

Test Plan:
- Reset, then both valid reads to addr 3 and 4 in the same cycle:
  - Cycle 0: req0 granted. Cycle 1: req0_rvalid with mem[3]; req1 granted.
  - Cycle 2: req1_rvalid with mem[4].
- Both valid continuously for 6 cycles, lock=0: grants alternate 0,1,0,1,0,1; exactly one ready per cycle.
- req1 writes 0xDEADBEEF to addr 7 with lock=1 for 3 consecutive writes while req0_valid=1:
  - req0_ready=0 for 3 cycles.
  - mem_MemWrite high 3 cycles.
  - req0 granted the cycle after lock drops.
- req0 reads addr 31, then addr 32:
  - First: rvalid, err=0, mem_MemRead=1.
  - Second: rvalid=1, err=1, rdata=0, mem_MemRead=0.
- req0 write to addr 40: err pulse in T+1, rvalid=0, mem_MemWrite stays 0.
- rst_n asserted the cycle after a read accept:
  - No rvalid pulse; all outputs 0 immediately.
  - After release, req1 alone valid is granted with no wait.
